// File: rtl/ddr3_test_pkg.sv
// rtl/ddr3_test_pkg.sv - shared state type, pattern helper and widths for the DDR3 loopback checker
package ddr3_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT_RESP,
        ST_DONE
    } test_state_t;

    localparam int ERROR_COUNT_BITWIDTH = 16;

    // Data written by request k and expected back from response k.
    function automatic logic [31:0] pattern_data(input logic [31:0] k);
        return k + 32'd1;
    endfunction

endpackage

// File: rtl/ddr3_read_response_checker.sv
// rtl/ddr3_read_response_checker.sv - in-order read response compare, error tally and response timeout
module ddr3_read_response_checker
    import ddr3_test_pkg::*;
#(
    parameter int ADDR_BITWIDTH    = 18,
    parameter int DQ_BITWIDTH      = 16,
    parameter int NUM_OF_TEST_DATA = 4,
    parameter int START_ADDRESS    = 0,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            active,
    input  logic                            read_accepted,
    input  logic [DQ_BITWIDTH-1:0]          resp_data,
    input  logic                            resp_valid,
    output logic [ERROR_COUNT_BITWIDTH-1:0] error_count,
    output logic [ADDR_BITWIDTH-1:0]        first_error_address,
    output logic                            all_received,
    output logic                            timeout_hit
);

    localparam int CNT_BITWIDTH   = $clog2(NUM_OF_TEST_DATA + 1);
    localparam int TIMER_BITWIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_BITWIDTH-1:0]   outstanding;
    logic [CNT_BITWIDTH-1:0]   received;
    logic [TIMER_BITWIDTH-1:0] timer;
    logic                      mismatch_seen;
    logic                      spurious;
    logic                      counted_resp;
    logic                      mismatch;
    logic [DQ_BITWIDTH-1:0]    expected_data;

    // Responses return in request order, so the received count is the response index.
    always_comb begin
        expected_data = DQ_BITWIDTH'(pattern_data(32'(received)));
        spurious      = resp_valid && (!active || outstanding == '0);
        counted_resp  = resp_valid && !spurious;
        mismatch      = counted_resp && (resp_data != expected_data);
    end

    assign all_received = (received == CNT_BITWIDTH'(NUM_OF_TEST_DATA));
    assign timeout_hit  = (timer == TIMER_BITWIDTH'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            outstanding         <= '0;
            received            <= '0;
            timer               <= '0;
            mismatch_seen       <= 1'b0;
            error_count         <= '0;
            first_error_address <= '0;
        end else begin
            if (read_accepted && !counted_resp) begin
                outstanding <= outstanding + 1'b1;
            end else if (!read_accepted && counted_resp) begin
                outstanding <= outstanding - 1'b1;
            end

            if (counted_resp) begin
                received <= received + 1'b1;
            end

            if ((spurious || mismatch) && error_count != '1) begin
                error_count <= error_count + 1'b1;
            end

            if (mismatch && !mismatch_seen) begin
                mismatch_seen       <= 1'b1;
                first_error_address <= ADDR_BITWIDTH'(START_ADDRESS) + ADDR_BITWIDTH'(received);
            end

            // Timer measures the gap since the last response; it parks once it hits the limit.
            if (resp_valid) begin
                timer <= '0;
            end else if (outstanding != '0 && !timeout_hit) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_loopback_traffic_checker.sv
// rtl/ddr3_loopback_traffic_checker.sv - write-then-read traffic generator with read-back checking
module ddr3_loopback_traffic_checker
    import ddr3_test_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int NUM_OF_TEST_DATA      = 4,
    parameter int START_ADDRESS         = 0,
    parameter int TIMEOUT_CYCLES        = 4096
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic                                              ctrl_ready,
    output logic                                              write_enable,
    output logic                                              read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                            i_user_data,
    input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
    input  logic                                              o_user_data_valid,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              pass,
    output logic                                              timeout,
    output logic [15:0]                                       error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

    localparam int ADDR_BITWIDTH = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int IDX_BITWIDTH  = $clog2(NUM_OF_TEST_DATA + 1);
    localparam logic [IDX_BITWIDTH-1:0]  LAST_IDX  = IDX_BITWIDTH'(NUM_OF_TEST_DATA - 1);
    localparam logic [ADDR_BITWIDTH-1:0] BASE_ADDR = ADDR_BITWIDTH'(START_ADDRESS);

    test_state_t             state;
    logic [IDX_BITWIDTH-1:0] req_idx;
    logic [IDX_BITWIDTH-1:0] next_idx;
    logic                    start_run;
    logic                    write_accepted;
    logic                    read_accepted;
    logic                    all_received;
    logic                    timeout_hit;

    assign start_run      = start && (state == ST_IDLE || state == ST_DONE);
    assign write_accepted = write_enable && ctrl_ready;
    assign read_accepted  = read_enable && ctrl_ready;
    assign next_idx       = req_idx + 1'b1;
    assign busy           = (state == ST_WRITE) || (state == ST_READ) || (state == ST_WAIT_RESP);
    assign done           = (state == ST_DONE);

    ddr3_read_response_checker #(
        .ADDR_BITWIDTH   (ADDR_BITWIDTH),
        .DQ_BITWIDTH     (DQ_BITWIDTH),
        .NUM_OF_TEST_DATA(NUM_OF_TEST_DATA),
        .START_ADDRESS   (START_ADDRESS),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_checker (
        .clk                (clk),
        .reset              (reset),
        .clear              (start_run),
        .active             (busy),
        .read_accepted      (read_accepted),
        .resp_data          (o_user_data),
        .resp_valid         (o_user_data_valid),
        .error_count        (error_count),
        .first_error_address(first_error_address),
        .all_received       (all_received),
        .timeout_hit        (timeout_hit)
    );

    // Request registers only move on acceptance, so they stay stable while the controller stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            req_idx             <= '0;
            write_enable        <= 1'b0;
            read_enable         <= 1'b0;
            i_user_data_address <= '0;
            i_user_data         <= '0;
            pass                <= 1'b0;
            timeout             <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state               <= ST_WRITE;
                        req_idx             <= '0;
                        write_enable        <= 1'b1;
                        i_user_data_address <= BASE_ADDR;
                        i_user_data         <= DQ_BITWIDTH'(pattern_data(32'd0));
                        pass                <= 1'b0;
                        timeout             <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (write_accepted) begin
                        if (req_idx == LAST_IDX) begin
                            state               <= ST_READ;
                            req_idx             <= '0;
                            write_enable        <= 1'b0;
                            read_enable         <= 1'b1;
                            i_user_data_address <= BASE_ADDR;
                            i_user_data         <= '0;
                        end else begin
                            req_idx             <= next_idx;
                            i_user_data_address <= BASE_ADDR + ADDR_BITWIDTH'(next_idx);
                            i_user_data         <= DQ_BITWIDTH'(pattern_data(32'(next_idx)));
                        end
                    end
                end
                ST_READ: begin
                    if (read_accepted) begin
                        if (req_idx == LAST_IDX) begin
                            state               <= ST_WAIT_RESP;
                            req_idx             <= '0;
                            read_enable         <= 1'b0;
                            i_user_data_address <= '0;
                        end else begin
                            req_idx             <= next_idx;
                            i_user_data_address <= BASE_ADDR + ADDR_BITWIDTH'(next_idx);
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (timeout_hit) begin
                        state   <= ST_DONE;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end else if (all_received) begin
                        state <= ST_DONE;
                        pass  <= (error_count == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_loopback_traffic_checker.sv
// tb/tb_ddr3_loopback_traffic_checker.sv - scoreboard bench with a loopback memory model
module tb_ddr3_loopback_traffic_checker;

    localparam int AW      = 18;
    localparam int DW      = 16;
    localparam int N       = 4;
    localparam int START   = 0;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ctrl_ready;
    logic          write_enable, read_enable;
    logic [AW-1:0] i_user_data_address;
    logic [DW-1:0] i_user_data;
    logic [DW-1:0] o_user_data;
    logic          o_user_data_valid;
    logic          busy, done, pass, timeout;
    logic [15:0]   error_count;
    logic [AW-1:0] first_error_address;

    ddr3_loopback_traffic_checker #(
        .ADDRESS_BITWIDTH     (15),
        .BANK_ADDRESS_BITWIDTH(3),
        .DQ_BITWIDTH          (DW),
        .NUM_OF_TEST_DATA     (N),
        .START_ADDRESS        (START),
        .TIMEOUT_CYCLES       (TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .ctrl_ready         (ctrl_ready),
        .write_enable       (write_enable),
        .read_enable        (read_enable),
        .i_user_data_address(i_user_data_address),
        .i_user_data        (i_user_data),
        .o_user_data        (o_user_data),
        .o_user_data_valid  (o_user_data_valid),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .timeout            (timeout),
        .error_count        (error_count),
        .first_error_address(first_error_address)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_write; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
    typedef struct { bit pass; bit timeout; int errors; logic [AW-1:0] first_addr; } res_t;
    typedef struct { int due; logic [DW-1:0] data; } resp_t;

    req_t          exp_req[$];
    res_t          exp_res[$];
    resp_t         pending[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    int ready_mode    = 0;
    int corrupt_idx   = -1;
    bit drop_last     = 1'b0;
    int read_count    = 0;
    int spurious_req  = 0;
    int cyc           = 0;
    int last_resp_cyc = 0;
    int first_acc_cyc = -1;
    int last_acc_cyc  = 0;
    int checks        = 0;
    int failures      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Loopback memory responder and ready pattern driver.
    initial begin
        int spurious_done;
        spurious_done     = 0;
        ctrl_ready        = 1'b0;
        o_user_data       = '0;
        o_user_data_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ctrl_ready = 1'b1;
                1:       ctrl_ready = ~ctrl_ready;
                default: ctrl_ready = 1'($urandom_range(0, 1));
            endcase
            o_user_data_valid = 1'b0;
            o_user_data       = '0;
            if (spurious_done < spurious_req) begin
                spurious_done++;
                o_user_data_valid = 1'b1;
                o_user_data       = 16'h1234;
            end else if (pending.size() > 0 && pending[0].due <= cyc) begin
                o_user_data_valid = 1'b1;
                o_user_data       = pending[0].data;
                void'(pending.pop_front());
                last_resp_cyc = cyc;
            end
        end
    end

    // Monitor: request scoreboard, hold-stability and end-of-run result checks.
    initial begin
        logic          hold, prev_done, p_we, p_re;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data, rdata;
        req_t          e;
        res_t          r;
        hold      = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold      = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (hold) begin
                    check("held_request", {p_we, p_re, p_addr, p_data},
                          {write_enable, read_enable, i_user_data_address, i_user_data});
                end
                hold   = (write_enable || read_enable) && !ctrl_ready;
                p_we   = write_enable;
                p_re   = read_enable;
                p_addr = i_user_data_address;
                p_data = i_user_data;
                if ((write_enable || read_enable) && ctrl_ready) begin
                    check("enables_exclusive", write_enable && read_enable, 0);
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    last_acc_cyc = cyc;
                    if (exp_req.size() == 0) begin
                        check("unexpected_request", 1, 0);
                    end else begin
                        e = exp_req.pop_front();
                        check("request_kind", write_enable, e.is_write);
                        check("request_addr", i_user_data_address, e.addr);
                        if (e.is_write) begin
                            check("write_data", i_user_data, e.data);
                            mem[i_user_data_address] = i_user_data;
                        end else begin
                            rdata = mem.exists(i_user_data_address) ? mem[i_user_data_address] : '0;
                            if (read_count == corrupt_idx) rdata = 16'h00FF;
                            if (!(drop_last && read_count == N - 1))
                                pending.push_back('{cyc + 2, rdata});
                            read_count++;
                        end
                    end
                end
                if (done && !prev_done) begin
                    if (exp_res.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        r = exp_res.pop_front();
                        check("requests_outstanding_at_done", exp_req.size(), 0);
                        check("pass", pass, r.pass);
                        check("timeout", timeout, r.timeout);
                        check("error_count", error_count, r.errors);
                        check("first_error_address", first_error_address, r.first_addr);
                        check("busy_at_done", busy, 0);
                    end
                end
                prev_done = done;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_write_enable"}, write_enable, 0);
        check({tag, "_read_enable"}, read_enable, 0);
        check({tag, "_address"}, i_user_data_address, 0);
        check({tag, "_data"}, i_user_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_error_count"}, error_count, 0);
        check({tag, "_first_error_address"}, first_error_address, 0);
    endtask

    task automatic load_expectations(input int corrupt, input bit drop, input bit with_result);
        int errs;
        for (int k = 0; k < N; k++) exp_req.push_back('{1'b1, AW'(START + k), DW'(k + 1)});
        for (int k = 0; k < N; k++) exp_req.push_back('{1'b0, AW'(START + k), '0});
        errs = (corrupt >= 0) ? 1 : 0;
        if (with_result)
            exp_res.push_back('{(errs == 0) && !drop, drop, errs,
                                (corrupt >= 0) ? AW'(START + corrupt) : AW'(0)});
    endtask

    task automatic pulse_start();
        @(posedge clk); #2;
        start = 1'b1;
        @(negedge clk);
        check("no_write_before_start_sampled", write_enable, 0);
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        check("first_write_enable", write_enable, 1);
        check("first_write_addr", i_user_data_address, START);
        check("first_write_data", i_user_data, 1);
    endtask

    task automatic run(input int mode, input int corrupt, input bit drop);
        int done_cyc;
        ready_mode    = mode;
        corrupt_idx   = corrupt;
        drop_last     = drop;
        read_count    = 0;
        first_acc_cyc = -1;
        load_expectations(corrupt, drop, 1'b1);
        pulse_start();
        for (int i = 0; i < 600 && !done; i++) @(negedge clk);
        check("run_reached_done", done, 1);
        done_cyc = cyc;
        if (mode == 0) check("no_gap_span", last_acc_cyc - first_acc_cyc, 2 * N - 1);
        if (drop) begin
            check("timeout_latency_window",
                  (done_cyc - last_resp_cyc >= TIMEOUT) && (done_cyc - last_resp_cyc <= TIMEOUT + 2), 1);
        end
        repeat (3) @(negedge clk);
        exp_req.delete();
        exp_res.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, cor;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #2;
        reset = 1'b0;

        // Spurious response while idle, then a clean run that must clear it.
        @(posedge clk); #2;
        spurious_req++;
        repeat (4) @(negedge clk);
        check("spurious_idle_error_count", error_count, 1);
        check("spurious_idle_busy", busy, 0);
        run(0, -1, 1'b0);

        run(1, -1, 1'b0);
        run(0, 2, 1'b0);
        run(0, -1, 1'b1);

        // Reset in the middle of the read phase.
        ready_mode  = 1;
        corrupt_idx = -1;
        drop_last   = 1'b0;
        read_count  = 0;
        load_expectations(-1, 1'b0, 1'b0);
        pulse_start();
        for (int i = 0; i < 200 && !read_enable; i++) @(negedge clk);
        check("reached_read_phase", read_enable, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        pending.delete();
        exp_req.delete();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("mid_read_reset");
        @(posedge clk); #2;
        reset = 1'b0;
        run(0, -1, 1'b0);

        for (int it = 0; it < 4; it++) begin
            mode = $urandom_range(0, 2);
            cor  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
            run(mode, cor, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
